// File: rtl/conv2d_mc_if.sv
// rtl/conv2d_mc_if.sv - Pixel-in / result-out handshake bundle for conv2d_mc.
interface conv2d_mc_if #(
  parameter int in_width_p     = 2,
  parameter int out_width_p    = 32,
  parameter int kernel_width_p = 3,
  parameter int weight_width_p = 2,
  parameter int channels_p     = 2
);
  logic                                                             valid_i;
  logic                                                             ready_o;
  logic [in_width_p-1:0]                                            data_i;
  logic [channels_p*kernel_width_p*kernel_width_p*weight_width_p-1:0] weights_i;
  logic                                                             valid_o;
  logic                                                             ready_i;
  logic [channels_p*out_width_p-1:0]                                data_o;
  logic                                                             last_o;

  modport slave (
    input  valid_i, data_i, weights_i, ready_i,
    output ready_o, valid_o, data_o, last_o
  );

  modport master (
    output valid_i, data_i, weights_i, ready_i,
    input  ready_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/conv2d_mc.sv
// rtl/conv2d_mc.sv - Streaming multi-channel KxK convolution; CONV2D_MC_RELU_EN clamps negative results to 0.
module conv2d_mc #(
  parameter int linewidth_px_p = 160,
  parameter int linecount_px_p = 120,
  parameter int in_width_p     = 2,
  parameter int out_width_p    = 32,
  parameter int kernel_width_p = 3,
  parameter int weight_width_p = 2,
  parameter int channels_p     = 2,
  parameter int stride_p       = 1
) (
  input logic        clk_i,
  input logic        reset_i,
  conv2d_mc_if.slave bus
);

  localparam int K      = kernel_width_p;
  localparam int xw     = $clog2(linewidth_px_p);
  localparam int yw     = $clog2(linecount_px_p);
  localparam int prod_w = weight_width_p + in_width_p + 1;
  localparam int sum_w  = prod_w + $clog2(K * K);
  localparam int acc_w  = (sum_w > out_width_p) ? sum_w : out_width_p;

  localparam logic [xw-1:0] x_first_c = xw'(K - 1);
  localparam logic [xw-1:0] x_last_c  = xw'(linewidth_px_p - 1);
  localparam logic [xw-1:0] x_mask_c  = xw'(stride_p - 1);
  localparam logic [yw-1:0] y_first_c = yw'(K - 1);
  localparam logic [yw-1:0] y_last_c  = yw'(linecount_px_p - 1);
  localparam logic [yw-1:0] y_mask_c  = yw'(stride_p - 1);

  logic [xw-1:0] x_q, x_d, x_off;
  logic [yw-1:0] y_q, y_d, y_off;

  logic [in_width_p-1:0] win_q [K][K];
  logic [in_width_p-1:0] win_d [K][K];
  logic [in_width_p-1:0] line_mem [K-1][linewidth_px_p];
  logic [in_width_p-1:0] lb_out [K-1];

  logic                              valid_q, valid_d;
  logic                              last_q, last_d;
  logic [channels_p*out_width_p-1:0] data_q, data_d;
  logic [channels_p*out_width_p-1:0] result;

  logic                      ready;
  logic                      accept;
  logic                      produce;
  logic signed [acc_w-1:0]   acc;
  logic signed [acc_w-1:0]   w_ext;
  logic signed [acc_w-1:0]   p_ext;
  logic signed [weight_width_p-1:0] w_s;
  logic [out_width_p-1:0]    chan;

  assign ready       = ~valid_q | bus.ready_i;
  assign accept      = bus.valid_i & ready;
  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.last_o  = last_q;

  // Shared write pointer x_q: each read returns the pixel one line older before it is overwritten.
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      lb_out[i] = line_mem[i][x_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      line_mem[0][x_q] <= bus.data_i;
      for (int i = 1; i < K - 1; i++) begin
        line_mem[i][x_q] <= lb_out[i-1];
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_q == x_last_c) begin
        x_d = '0;
        y_d = (y_q == y_last_c) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Bottom row is the current line; row K-2-i comes from line buffer i.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = lb_out[K-2-r];
      end
      win_d[K-1][K-1] = bus.data_i;
    end
  end

  assign x_off   = x_q - x_first_c;
  assign y_off   = y_q - y_first_c;
  assign produce = accept && (x_q >= x_first_c) && (y_q >= y_first_c) &&
                   ((x_off & x_mask_c) == '0) && ((y_off & y_mask_c) == '0);

  // The window after this accept already holds the current pixel, so convolve win_d.
  always_comb begin
    result = '0;
    acc    = '0;
    w_s    = '0;
    w_ext  = '0;
    p_ext  = '0;
    chan   = '0;
    for (int ch = 0; ch < channels_p; ch++) begin
      acc = '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          w_s   = bus.weights_i[((ch*K + r)*K + c)*weight_width_p +: weight_width_p];
          w_ext = acc_w'(w_s);
          p_ext = acc_w'({1'b0, win_d[r][c]});
          if (in_width_p == 1) begin
            if (win_d[r][c] != '0) acc = acc + w_ext;
          end else begin
            acc = acc + w_ext * p_ext;
          end
        end
      end
      chan = acc[out_width_p-1:0];
`ifdef CONV2D_MC_RELU_EN
      if (chan[out_width_p-1]) chan = '0;
`else
      chan = chan;
`endif
      result[ch*out_width_p +: out_width_p] = chan;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (produce) begin
      valid_d = 1'b1;
      data_d  = result;
      last_d  = (x_q == x_last_c) && (y_q == y_last_c);
    end else if (ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      win_q   <= win_d;
    end
  end

endmodule
